// File: rtl/prior_rr_arbiter_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
// The master side drives enable and req; the slave side, which is the arbiter,
// returns the registered one-hot grant, the owner index and the valid flag.
interface prior_rr_arbiter_if #(
  parameter int Width = 8
) ();

  localparam int IDW = (Width > 1) ? $clog2(Width) : 1;

  logic             enable;
  logic [Width-1:0] req;
  logic [Width-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_valid;

  modport master (
    output enable,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  modport slave (
    input  enable,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid
  );

endinterface

// File: rtl/prior_rr_arbiter.sv
// Round-robin arbiter sharing one resource between Width requesters.
// A rotating-priority search picks the first requester at or after the priority
// pointer. An IDLE/BUSY FSM owns the grant; a hold counter forces the owner to
// release after MAX_HOLD cycles when somebody else is waiting (MAX_HOLD=0 never
// forces a release). On every release the pointer moves just past the old owner,
// and the remaining requesters are re-arbitrated on the same edge, so a handoff
// costs no idle cycle.
module prior_rr_arbiter #(
  parameter int Width    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  prior_rr_arbiter_if.slave    bus
);

  localparam int IDW = (Width > 1) ? $clog2(Width) : 1;
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [IDW-1:0] LAST_ID   = IDW'(Width - 1);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam bit             HOLD_EN   = (MAX_HOLD > 0);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;

  logic [Width-1:0] owner_oh;
  logic [Width-1:0] others;
  logic             others_pend;
  logic             owner_req;
  logic             at_limit;
  logic             timeout;
  logic             release_w;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW:0]     pick_idle;
  logic [IDW:0]     pick_busy;

  // First set bit of r searching upward from p with wrap at Width-1.
  // Result is {found, index}. The loop walks offsets from the farthest to the
  // nearest so the nearest hit is the last one written and therefore wins.
  // The wrap uses an explicit compare, so Width need not be a power of two.
  function automatic logic [IDW:0] sel(input logic [Width-1:0] r,
                                       input logic [IDW-1:0]   p);
    logic [IDW:0] res;
    logic [IDW:0] pos;
    res = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      pos = {1'b0, p} + (IDW+1)'(i);
      if (pos >= (IDW+1)'(Width)) begin
        pos = pos - (IDW+1)'(Width);
      end
      if (r[pos[IDW-1:0]]) begin
        res = {1'b1, pos[IDW-1:0]};
      end
    end
    return res;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [Width-1:0] onehot(input logic [IDW-1:0] id);
    logic [Width-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Release conditions and both candidate selections, derived from current state.
  always_comb begin
    owner_oh    = onehot(gnt_id_q);
    others      = bus.req & ~owner_oh;
    others_pend = |others;
    owner_req   = |(bus.req & owner_oh);
    at_limit    = HOLD_EN && (hold_q == HOLD_LAST);
    timeout     = at_limit && others_pend;
    release_w   = !owner_req || timeout;
    ptr_nxt     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
    pick_idle   = sel(bus.req, ptr_q);
    pick_busy   = sel(others, ptr_nxt);
  end

  // Grant FSM: next state, next grant, pointer and hold counter.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.enable && pick_idle[IDW]) begin
          gnt_id_d = pick_idle[IDW-1:0];
          gnt_d    = onehot(pick_idle[IDW-1:0]);
          hold_d   = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (!bus.enable) begin
          // Disable wins over everything else; the pointer stays where it was.
          gnt_d   = '0;
          hold_d  = '0;
          state_d = IDLE;
        end else if (release_w) begin
          // The old owner drops to lowest priority; its own bit is masked
          // so a timed-out owner cannot win the same re-arbitration.
          ptr_d  = ptr_nxt;
          hold_d = '0;
          if (pick_busy[IDW]) begin
            gnt_id_d = pick_busy[IDW-1:0];
            gnt_d    = onehot(pick_busy[IDW-1:0]);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (HOLD_EN) begin
          // Owner keeps the grant; with nobody waiting at the limit the
          // counter restarts instead of forcing a release.
          hold_d = at_limit ? '0 : hold_q + HCW'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;

endmodule

// File: tb/tb_prior_rr_arbiter.sv
// Directed bench for prior_rr_arbiter: a table of single-cycle vectors with
// hand-computed grants, then hand-written sequences for asynchronous reset,
// timeout rotation and unlimited hold.
module tb_prior_rr_arbiter;

  logic clk;
  logic rst;

  prior_rr_arbiter_if #(.Width(8)) if0 ();
  prior_rr_arbiter_if #(.Width(8)) if1 ();

  prior_rr_arbiter #(.Width(8), .MAX_HOLD(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  prior_rr_arbiter #(.Width(8), .MAX_HOLD(0)) u_dut_unl (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[30];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Full check of the first DUT's outputs against an expected grant vector.
  task automatic check_out0(input string name, input int idx, input logic [7:0] eg,
                            input logic [2:0] eid);
    check({name, ".gnt"}, idx, {24'h0, if0.gnt}, {24'h0, eg});
    check({name, ".valid"}, idx, {31'h0, if0.gnt_valid}, {31'h0, (eg != 8'h00)});
    if (eg != 8'h00) check({name, ".id"}, idx, {29'h0, if0.gnt_id}, {29'h0, eid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vectors run back to back from reset (ptr=0, MAX_HOLD=4).
    tbl[0]  = '{1'b1, 8'h2C, 8'h04, 3'd2}; // first grant from ptr 0
    tbl[1]  = '{1'b1, 8'h28, 8'h08, 3'd3}; // drop bit2 -> id3, no gap
    tbl[2]  = '{1'b1, 8'h20, 8'h20, 3'd5}; // drop bit3 -> id5
    tbl[3]  = '{1'b1, 8'h00, 8'h00, 3'd0}; // release, ptr=6
    tbl[4]  = '{1'b1, 8'h03, 8'h01, 3'd0}; // wrap: id0, not id1
    tbl[5]  = '{1'b1, 8'h00, 8'h00, 3'd0}; // ptr=1
    tbl[6]  = '{1'b1, 8'h10, 8'h10, 3'd4}; // single request
    tbl[7]  = '{1'b1, 8'h00, 8'h00, 3'd0}; // ptr=5
    tbl[8]  = '{1'b0, 8'hFF, 8'h00, 3'd0}; // disabled: no grant
    tbl[9]  = '{1'b0, 8'hFF, 8'h00, 3'd0};
    tbl[10] = '{1'b1, 8'hFF, 8'h20, 3'd5}; // search starts at 5
    tbl[11] = '{1'b0, 8'hFF, 8'h00, 3'd0}; // enable drop mid-grant
    tbl[12] = '{1'b1, 8'hFF, 8'h20, 3'd5}; // ptr was left at 5
    tbl[13] = '{1'b1, 8'h01, 8'h01, 3'd0}; // owner drops, ptr=6 -> id0
    tbl[14] = '{1'b1, 8'h81, 8'h01, 3'd0}; // hold 1
    tbl[15] = '{1'b1, 8'h81, 8'h01, 3'd0}; // hold 2
    tbl[16] = '{1'b1, 8'h81, 8'h01, 3'd0}; // hold 3
    tbl[17] = '{1'b1, 8'h81, 8'h80, 3'd7}; // timeout -> id7
    tbl[18] = '{1'b1, 8'h80, 8'h80, 3'd7}; // hold 1
    tbl[19] = '{1'b1, 8'h80, 8'h80, 3'd7}; // hold 2
    tbl[20] = '{1'b1, 8'h80, 8'h80, 3'd7}; // hold 3
    tbl[21] = '{1'b1, 8'h80, 8'h80, 3'd7}; // limit, nobody waiting: hold 0
    tbl[22] = '{1'b1, 8'h80, 8'h80, 3'd7}; // hold 1
    tbl[23] = '{1'b1, 8'h81, 8'h80, 3'd7}; // hold 2
    tbl[24] = '{1'b1, 8'h81, 8'h80, 3'd7}; // hold 3
    tbl[25] = '{1'b1, 8'h81, 8'h01, 3'd0}; // timeout, ptr=0 -> id0
    tbl[26] = '{1'b1, 8'h00, 8'h00, 3'd0}; // ptr=1
    tbl[27] = '{1'b1, 8'h02, 8'h02, 3'd1};
    tbl[28] = '{1'b1, 8'h04, 8'h04, 3'd2}; // new req same edge as release
    tbl[29] = '{1'b1, 8'h00, 8'h00, 3'd0};

    rst        = 1'b1;
    if0.enable = 1'b0;
    if0.req    = '0;
    if1.enable = 1'b0;
    if1.req    = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst0.gnt", 0, {24'h0, if0.gnt}, 32'h0);
    check("rst0.id", 0, {29'h0, if0.gnt_id}, 32'h0);
    check("rst0.valid", 0, {31'h0, if0.gnt_valid}, 32'h0);
    check("rst1.gnt", 0, {24'h0, if1.gnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if0.enable = tbl[i].en;
      if0.req    = tbl[i].req;
      @(posedge clk);
      #1;
      check_out0("vec", i, tbl[i].gnt, tbl[i].id);
    end

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    if0.enable = 1'b1;
    if0.req    = 8'h10;
    @(posedge clk);
    #1;
    check_out0("pre_rst", 0, 8'h10, 3'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.gnt", 0, {24'h0, if0.gnt}, 32'h0);
    check("async_rst.valid", 0, {31'h0, if0.gnt_valid}, 32'h0);
    check("async_rst.id", 0, {29'h0, if0.gnt_id}, 32'h0);

    // Timeout rotation with every requester active; first grant after reset is id0.
    @(negedge clk);
    rst        = 1'b0;
    if0.enable = 1'b1;
    if0.req    = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      logic [2:0] eid;
      logic [7:0] eg;
      eid = 3'((k / 4) % 8);
      eg  = 8'h01 << eid;
      @(posedge clk);
      #1;
      check_out0("rot", k, eg, eid);
      check("rot.onehot", k, {31'h0, $onehot(if0.gnt)}, 32'h1);
    end
    @(negedge clk);
    if0.req    = '0;
    if0.enable = 1'b0;

    // Unlimited hold on the MAX_HOLD=0 instance.
    if1.enable = 1'b1;
    if1.req    = 8'h81;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      check("unl.gnt", k, {24'h0, if1.gnt}, 32'h01);
    end
    check("unl.id", 0, {29'h0, if1.gnt_id}, 32'h0);
    @(negedge clk);
    if1.req = 8'h80;
    @(posedge clk);
    #1;
    check("unl_hand.gnt", 0, {24'h0, if1.gnt}, 32'h80);
    check("unl_hand.id", 0, {29'h0, if1.gnt_id}, 32'h7);
    check("unl_hand.valid", 0, {31'h0, if1.gnt_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
